shift_add_step_counter: RTL and testbench



---
 rtl/shift_add_step_counter.sv | 90 +++++++++
 tb/tb_shift_add_step_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_step_counter.sv
// Iteration counter for the shift-add multiplier control unit.
// It counts the multiplier bits consumed per operation, at 1 or 2 bits per
// step, and gates counting with a datapath step enable. K rises once all
// N bits are consumed, or earlier when the remaining multiplier is zero.
// Every output is registered, so no combinational path runs from an input
// to an output.
module shift_add_step_counter #(
  parameter int N         = 4,
  parameter bit RADIX4_EN = 1'b1,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Load,
  input  logic          En,
  input  logic          Mode,
  input  logic          Zero,
  output logic [CW-1:0] Count,
  output logic          K,
  output logic          Done_p,
  output logic          Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // N at the widths used for the compare (CW+1 bits) and for the stored count (CW bits).
  localparam logic [CW:0]   N_EXT = (CW + 1)'(N);
  localparam logic [CW-1:0] N_CW  = CW'(N);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_k;
  logic          r_done_p;
  logic          r_busy;
  logic          r_step2;   // 1 = two bits per step, latched on Load

  logic [CW:0]   w_step;
  logic [CW:0]   w_sum;
  logic          w_finish;

  // The sum is one bit wider than Count, so Count + step cannot wrap before
  // it is compared against N.
  assign w_step   = r_step2 ? (CW + 1)'(2) : (CW + 1)'(1);
  assign w_sum    = {1'b0, r_count} + w_step;
  assign w_finish = Zero || (w_sum >= N_EXT);

  // State, count and status flags. Reset comes first, then Load, then the En step.
  // NOTE: sequential state uses non-blocking (<=) assignments, so every register
  // in this block samples its old value on the edge, whatever the statement order.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_k      <= 1'b0;
      r_done_p <= 1'b0;
      r_busy   <= 1'b0;
      r_step2  <= 1'b0;
    end else if (Load) begin
      r_state  <= S_RUN;
      r_count  <= '0;
      r_k      <= 1'b0;
      r_done_p <= 1'b0;
      r_busy   <= 1'b1;
      r_step2  <= RADIX4_EN && Mode;
    end else begin
      // Done_p is high only on the first cycle in DONE.
      r_done_p <= 1'b0;
      if (r_state == S_RUN && En) begin
        if (w_finish) begin
          // Saturate at N. An odd N in 2-bit mode counts only 1 on the last step.
          r_state  <= S_DONE;
          r_count  <= N_CW;
          r_k      <= 1'b1;
          r_done_p <= 1'b1;
          r_busy   <= 1'b0;
        end else begin
          r_count  <= w_sum[CW-1:0];
        end
      end
    end
  end

  assign Count  = r_count;
  assign K      = r_k;
  assign Done_p = r_done_p;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_shift_add_step_counter.sv
// Bench for shift_add_step_counter. Three configurations share one stimulus
// stream: (N=4, radix-4 on), (N=5, radix-4 on) and (N=5, radix-4 off).
// Each configuration has its own behavioural reference model, and all
// outputs are compared one time unit after every rising edge.
module tb_shift_add_step_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic zero = 1'b0;

  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic       k_a, k_b, k_c;
  logic       dp_a, dp_b, dp_c;
  logic       busy_a, busy_b, busy_c;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  shift_add_step_counter #(.N(4), .RADIX4_EN(1'b1)) u_a (
    .Clk(clk), .Rst_n(rst_n), .Load(load), .En(en), .Mode(mode), .Zero(zero),
    .Count(cnt_a), .K(k_a), .Done_p(dp_a), .Busy(busy_a));

  shift_add_step_counter #(.N(5), .RADIX4_EN(1'b1)) u_b (
    .Clk(clk), .Rst_n(rst_n), .Load(load), .En(en), .Mode(mode), .Zero(zero),
    .Count(cnt_b), .K(k_b), .Done_p(dp_b), .Busy(busy_b));

  shift_add_step_counter #(.N(5), .RADIX4_EN(1'b0)) u_c (
    .Clk(clk), .Rst_n(rst_n), .Load(load), .En(en), .Mode(mode), .Zero(zero),
    .Count(cnt_c), .K(k_c), .Done_p(dp_c), .Busy(busy_c));

  // Reference model: one entry per configuration. The model tracks bits
  // consumed, bits per step, and whether an operation is in progress.
  int m_n   [3] = '{4, 5, 5};
  bit m_r4  [3] = '{1'b1, 1'b1, 1'b0};
  int m_cnt [3];
  int m_step[3];
  bit m_run [3];
  bit m_k   [3];
  bit m_dp  [3];

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with the given input values.
  task automatic model_edge(input bit r, input bit l, input bit e, input bit md, input bit z);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        m_run[i] = 0; m_cnt[i] = 0; m_k[i] = 0; m_dp[i] = 0; m_step[i] = 1;
      end else if (l) begin
        m_run[i] = 1; m_cnt[i] = 0; m_k[i] = 0; m_dp[i] = 0;
        m_step[i] = (m_r4[i] && md) ? 2 : 1;
      end else begin
        m_dp[i] = 0;
        if (m_run[i] && e) begin
          if (z || m_cnt[i] + m_step[i] >= m_n[i]) begin
            m_cnt[i] = m_n[i]; m_run[i] = 0; m_k[i] = 1; m_dp[i] = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + m_step[i];
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_count", int'(cnt_a), m_cnt[0]);
    check("a_k",     int'(k_a),   int'(m_k[0]));
    check("a_donep", int'(dp_a),  int'(m_dp[0]));
    check("a_busy",  int'(busy_a), int'(m_run[0]));
    check("b_count", int'(cnt_b), m_cnt[1]);
    check("b_k",     int'(k_b),   int'(m_k[1]));
    check("b_donep", int'(dp_b),  int'(m_dp[1]));
    check("b_busy",  int'(busy_b), int'(m_run[1]));
    check("c_count", int'(cnt_c), m_cnt[2]);
    check("c_k",     int'(k_c),   int'(m_k[2]));
    check("c_donep", int'(dp_c),  int'(m_dp[2]));
    check("c_busy",  int'(busy_c), int'(m_run[2]));
  endtask

  // One clock cycle: drive on the falling edge, step the model on the rising
  // edge, then sample the DUTs 1 time unit later.
  task automatic cyc(input bit r, input bit l, input bit e, input bit md, input bit z);
    @(negedge clk);
    rst_n = r; load = l; en = e; mode = md; zero = z;
    @(posedge clk);
    model_edge(r, l, e, md, z);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset for two cycles, then En pulses with no Load: nothing may move.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_count", int'(cnt_a), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
    check("idle_count", int'(cnt_a), 0);
    check("idle_busy", int'(busy_a), 0);

    // N=4, Mode=0: Load, then En held high. Count steps 1,2,3,4.
    cyc(1, 1, 0, 0, 0);
    check("load_busy", int'(busy_a), 1);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("m0_count3", int'(cnt_a), 3);
    cyc(1, 0, 1, 0, 0);
    check("m0_k", int'(k_a), 1);
    check("m0_donep", int'(dp_a), 1);
    cyc(1, 0, 1, 0, 0);
    check("m0_donep_low", int'(dp_a), 0);
    check("m0_k_hold", int'(k_a), 1);

    // Mode=1, En on alternate cycles. Mode is changed mid-run and must be ignored.
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    check("m1_count2", int'(cnt_a), 2);
    check("m1_nomode_c", int'(cnt_c), 1);
    cyc(1, 0, 0, 0, 0);
    check("m1_hold", int'(cnt_a), 2);
    cyc(1, 0, 1, 0, 0);
    check("m1_k", int'(k_a), 1);
    check("m1_busy", int'(busy_a), 0);
    cyc(1, 0, 0, 1, 0);

    // N=5, Mode=1, En continuous: Count 2,4,5, where the last step is saturated.
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    check("n5_count4", int'(cnt_b), 4);
    cyc(1, 0, 1, 1, 0);
    check("n5_count5", int'(cnt_b), 5);
    check("n5_k", int'(k_b), 1);

    // Early finish. Zero without En is ignored, and Zero with En finishes.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0);
    check("ef_count1", int'(cnt_a), 1);
    cyc(1, 0, 1, 0, 1);
    check("ef_count4", int'(cnt_a), 4);
    check("ef_donep", int'(dp_a), 1);

    // Load in DONE clears K on the next edge.
    cyc(1, 1, 0, 0, 0);
    check("reload_k", int'(k_a), 0);
    // Load during RUN at Count=2 restarts from 0.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("restart_count", int'(cnt_a), 0);
    check("restart_busy", int'(busy_a), 1);
    // Reset at Count=3.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("midrst_count", int'(cnt_a), 0);
    // Reset asserted together with Load: reset wins.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    check("rstload_busy", int'(busy_a), 0);

    // Random traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 40) != 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
